// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load channels and the register-file port.
// Signals:
//   a_valid/a_ready/a_addr/a_data  channel A (ALU writeback) request
//   b_valid/b_ready/b_addr/b_data  channel B (load writeback) request
//   wr_en/wr_addr/wr_data          registered register-file write port
//   drop_err                       pulse when a protected-address write is discarded
//   pend_mask                      one bit per register with a write in flight
//   busy                           any buffer full or a write on the port
// Modports: master = request source / write consumer, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                         a_valid;
    logic                         a_ready;
    logic [ADDR_WIDTH-1:0]        a_addr;
    logic [DATA_WIDTH-1:0]        a_data;
    logic                         b_valid;
    logic                         b_ready;
    logic [ADDR_WIDTH-1:0]        b_addr;
    logic [DATA_WIDTH-1:0]        b_data;
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         drop_err;
    logic [(1<<ADDR_WIDTH)-1:0]   pend_mask;
    logic                         busy;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  wr_en, wr_addr, wr_data, drop_err, pend_mask, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output wr_en, wr_addr, wr_data, drop_err, pend_mask, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-channel writeback arbiter in front of a single register-file write port.
// Each channel has a one-entry holding buffer; full buffers are granted one per
// cycle (round-robin on ties) and drive a registered write port. Writes aimed at
// the reserved base-pointer register PROT_ADDR are discarded with a drop_err pulse.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   regfile_wb_arbiter_if.slave (channel A/B requests, write port, status)
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int PROT_ADDR  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PROT = ADDR_WIDTH'(PROT_ADDR);

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_t;

    // registered state
    logic                  a_full, b_full;
    logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q;
    logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
    chan_t                 last_grant;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  drop_q;

    // next-state
    logic                  a_full_d, b_full_d;
    logic [ADDR_WIDTH-1:0] a_addr_d, b_addr_d;
    logic [DATA_WIDTH-1:0] a_data_d, b_data_d;
    chan_t                 last_grant_d;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic                  drop_d;

    grant_t                grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREG-1:0]       pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_full     <= 1'b0;
            b_full     <= 1'b0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            last_grant <= CH_B;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            a_full     <= a_full_d;
            b_full     <= b_full_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            last_grant <= last_grant_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            drop_q     <= drop_d;
        end
    end

    // Grant selection: single full buffer wins; on a tie the channel not
    // granted last time wins.
    always_comb begin
        grant = GNT_NONE;
        if (a_full && b_full)
            grant = (last_grant == CH_B) ? GNT_A : GNT_B;
        else if (a_full)
            grant = GNT_A;
        else if (b_full)
            grant = GNT_B;
    end

    always_comb begin
        a_full_d     = a_full;
        b_full_d     = b_full;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        a_data_d     = a_data_q;
        b_data_d     = b_data_q;
        last_grant_d = last_grant;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        drop_d       = 1'b0;
        sel_addr     = a_addr_q;
        sel_data     = a_data_q;

        case (grant)
            GNT_A: begin
                a_full_d     = 1'b0;
                last_grant_d = CH_A;
                sel_addr     = a_addr_q;
                sel_data     = a_data_q;
            end
            GNT_B: begin
                b_full_d     = 1'b0;
                last_grant_d = CH_B;
                sel_addr     = b_addr_q;
                sel_data     = b_data_q;
            end
            default: ;
        endcase

        if (grant != GNT_NONE) begin
            if (sel_addr == PROT) begin
                drop_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_data;
            end
        end

        // Accept only into a buffer that was empty at the start of the cycle,
        // so a buffer freed by this edge's grant cannot refill on the same edge.
        if (bus.a_valid && !a_full) begin
            a_full_d = 1'b1;
            a_addr_d = bus.a_addr;
            a_data_d = bus.a_data;
        end
        if (bus.b_valid && !b_full) begin
            b_full_d = 1'b1;
            b_addr_d = bus.b_addr;
            b_data_d = bus.b_data;
        end
    end

    always_comb begin
        pend = '0;
        if (a_full)  pend[a_addr_q]  = 1'b1;
        if (b_full)  pend[b_addr_q]  = 1'b1;
        if (wr_en_q) pend[wr_addr_q] = 1'b1;
    end

    assign bus.a_ready   = ~a_full;
    assign bus.b_ready   = ~b_full;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.drop_err  = drop_q;
    assign bus.pend_mask = pend;
    assign bus.busy      = a_full | b_full | wr_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a queue-based model of the two
// channels is compared against the DUT every cycle, directed scenarios pin
// literal values, and a randomized phase exercises arbitration and reset.
module tb_regfile_wb_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NREG = 1 << AW;
    localparam int PROT = 15;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .PROT_ADDR (PROT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          aq[$];
    ent_t          bq[$];
    bit            prefer_a;
    bit            live = 0;
    logic          m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic          m_drop;
    logic [DW-1:0] model_rf [NREG];
    logic [DW-1:0] dut_rf   [NREG];

    initial begin
        for (int i = 0; i < NREG; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                aq.delete();
                bq.delete();
                prefer_a  = 1'b1;
                m_wr_en   = 1'b0;
                m_wr_addr = '0;
                m_wr_data = '0;
                m_drop    = 1'b0;
                live      = 1'b1;
            end else if (live) begin
                bit   a_empty;
                bit   b_empty;
                bit   took;
                ent_t e;
                a_empty = (aq.size() == 0);
                b_empty = (bq.size() == 0);
                m_wr_en = 1'b0;
                m_drop  = 1'b0;
                took    = 1'b0;
                if (!a_empty && (b_empty || prefer_a)) begin
                    e = aq.pop_front(); prefer_a = 1'b0; took = 1'b1;
                end else if (!b_empty) begin
                    e = bq.pop_front(); prefer_a = 1'b1; took = 1'b1;
                end
                if (took) begin
                    if (int'(e.addr) == PROT) begin
                        m_drop = 1'b1;
                    end else begin
                        m_wr_en   = 1'b1;
                        m_wr_addr = e.addr;
                        m_wr_data = e.data;
                        model_rf[e.addr] = e.data;
                    end
                end
                if (bus.a_valid && a_empty) aq.push_back('{bus.a_addr, bus.a_data});
                if (bus.b_valid && b_empty) bq.push_back('{bus.b_addr, bus.b_data});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (live) begin
            logic [NREG-1:0] m_pend;
            m_pend = '0;
            if (aq.size() != 0) m_pend[aq[0].addr] = 1'b1;
            if (bq.size() != 0) m_pend[bq[0].addr] = 1'b1;
            if (m_wr_en)        m_pend[m_wr_addr]  = 1'b1;
            chk("a_ready",   64'(bus.a_ready),   64'(aq.size() == 0));
            chk("b_ready",   64'(bus.b_ready),   64'(bq.size() == 0));
            chk("wr_en",     64'(bus.wr_en),     64'(m_wr_en));
            chk("wr_addr",   64'(bus.wr_addr),   64'(m_wr_addr));
            chk("wr_data",   64'(bus.wr_data),   64'(m_wr_data));
            chk("drop_err",  64'(bus.drop_err),  64'(m_drop));
            chk("pend_mask", 64'(bus.pend_mask), 64'(m_pend));
            chk("busy",      64'(bus.busy),
                64'((aq.size() != 0) || (bq.size() != 0) || m_wr_en));
            if (bus.wr_en === 1'b1) dut_rf[bus.wr_addr] = bus.wr_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] prev_addr;
        int            nwr;
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_a_ready", 64'(bus.a_ready), 64'd1);
        chk("rst_b_ready", 64'(bus.b_ready), 64'd1);
        chk("rst_pend",    64'(bus.pend_mask), 64'd0);
        chk("rst_busy",    64'(bus.busy), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);

        // single write
        bus.a_valid = 1'b1; bus.a_addr = 4'd3; bus.a_data = 32'hDEADBEEF;
        tick();
        idle();
        chk("sw_a_ready", 64'(bus.a_ready), 64'd0);
        chk("sw_pend",    64'(bus.pend_mask), 64'h0008);
        chk("sw_wr_en0",  64'(bus.wr_en), 64'd0);
        tick();
        chk("sw_wr_en",   64'(bus.wr_en), 64'd1);
        chk("sw_wr_addr", 64'(bus.wr_addr), 64'd3);
        chk("sw_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
        tick();
        chk("sw_wr_en_off", 64'(bus.wr_en), 64'd0);
        chk("sw_busy_off",  64'(bus.busy), 64'd0);

        // tie after reset: A wins first
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 32'd1;
        bus.b_valid = 1'b1; bus.b_addr = 4'd2; bus.b_data = 32'd2;
        tick();
        idle();
        chk("tie_pend", 64'(bus.pend_mask), 64'h0006);
        tick();
        chk("tie_w1_en",   64'(bus.wr_en), 64'd1);
        chk("tie_w1_addr", 64'(bus.wr_addr), 64'd1);
        tick();
        chk("tie_w2_en",   64'(bus.wr_en), 64'd1);
        chk("tie_w2_addr", 64'(bus.wr_addr), 64'd2);
        chk("tie_w2_data", 64'(bus.wr_data), 64'd2);
        tick();

        // protected register: wr_* keep the last write (addr 2, data 2)
        bus.b_valid = 1'b1; bus.b_addr = 4'd15; bus.b_data = 32'h1234;
        tick();
        idle();
        tick();
        chk("prot_wr_en",   64'(bus.wr_en), 64'd0);
        chk("prot_drop",    64'(bus.drop_err), 64'd1);
        chk("prot_wr_addr", 64'(bus.wr_addr), 64'd2);
        chk("prot_wr_data", 64'(bus.wr_data), 64'd2);
        tick();
        chk("prot_drop_off", 64'(bus.drop_err), 64'd0);

        // same address: B's data is final
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 32'hA;
        bus.b_valid = 1'b1; bus.b_addr = 4'd5; bus.b_data = 32'hB;
        tick();
        idle();
        tick();
        chk("same_w1", 64'(bus.wr_data), 64'hA);
        tick();
        chk("same_w2", 64'(bus.wr_data), 64'hB);
        tick();
        chk("same_rf5", 64'(dut_rf[5]), 64'hB);

        // reset mid-flight
        bus.a_valid = 1'b1; bus.a_addr = 4'd7; bus.a_data = 32'h77;
        bus.b_valid = 1'b1; bus.b_addr = 4'd8; bus.b_data = 32'h88;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_wr_en",   64'(bus.wr_en), 64'd0);
        chk("mid_pend",    64'(bus.pend_mask), 64'd0);
        chk("mid_a_ready", 64'(bus.a_ready), 64'd1);
        chk("mid_b_ready", 64'(bus.b_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_write", 64'(bus.wr_en), 64'd0);
        end

        // saturation: grants alternate A (addr 1) / B (addr 2)
        do_reset();
        prev_addr = 4'd2;
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 32'(100 + i);
            bus.b_valid = 1'b1; bus.b_addr = 4'd2; bus.b_data = 32'(200 + i);
            tick();
            if (bus.wr_en === 1'b1) begin
                chk("sat_alt", 64'(bus.wr_addr), (prev_addr == 4'd1) ? 64'd2 : 64'd1);
                prev_addr = bus.wr_addr;
                nwr++;
            end
        end
        idle();
        chk("sat_count", 64'(nwr), 64'd19);
        for (int i = 0; i < 4; i++) tick();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            bus.a_valid = $urandom_range(0, 2) != 0;
            bus.b_valid = $urandom_range(0, 2) != 0;
            bus.a_addr  = AW'($urandom_range(0, NREG - 1));
            bus.b_addr  = AW'($urandom_range(0, NREG - 1));
            bus.a_data  = $urandom;
            bus.b_data  = $urandom;
            tick();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) tick();

        for (int r = 0; r < NREG; r++)
            chk("final_rf", 64'(dut_rf[r]), 64'(model_rf[r]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL be configured by these parameters:
- DATA_WIDTH, default 32, register data width.
- ADDR_WIDTH, default 4, register address width (16 registers).
- PROT_ADDR, default 15, reserved base-pointer register; it SHALL never be written through this block.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  channel A (ALU writeback) request valid.
- a_ready  out  1  channel A holding buffer empty.
- a_addr  in  ADDR_WIDTH  channel A destination register.
- a_data  in  DATA_WIDTH  channel A write data.
- b_valid  in  1  channel B (load writeback) request valid.
- b_ready  out  1  channel B holding buffer empty.
- b_addr  in  ADDR_WIDTH  channel B destination register.
- b_data  in  DATA_WIDTH  channel B write data.
- wr_en  out  1  register-file write enable, registered.
- wr_addr  out  ADDR_WIDTH  register-file write address, registered.
- wr_data  out  DATA_WIDTH  register-file write data, registered.
- drop_err  out  1  one-cycle pulse when a write to PROT_ADDR is discarded.
- pend_mask  out  2**ADDR_WIDTH  bit i set while a write to register i is buffered or on wr_*.
- busy  out  1  any buffer full or wr_en high.

Function
REQ-003 Each channel SHALL own a one-entry holding buffer (full flag, addr, data); x_ready SHALL equal NOT full, with no combinational path from x_valid.
REQ-004 A transfer SHALL occur on an edge where x_valid and x_ready are both high; the buffer SHALL be full after that edge.
REQ-005 The arbiter SHALL evaluate the buffers every cycle:
- Exactly one buffer full: that buffer is granted.
- Both full: grant the channel not granted last (round-robin bit last_grant).
- Neither full: no grant.
REQ-006 On a grant edge, the granted buffer SHALL clear, last_grant SHALL update to the granted channel, and wr_addr/wr_data SHALL load the entry.
REQ-007 On a grant edge, wr_en SHALL go high for exactly one cycle unless the entry addr equals PROT_ADDR.
REQ-008 A granted entry with addr == PROT_ADDR SHALL instead:
- hold wr_en low;
- leave wr_addr/wr_data unchanged;
- pulse drop_err high for one cycle.
REQ-009 wr_en SHALL be 0 in any cycle following an edge with no grant.
REQ-010 Latency: accept at edge N → grant at edge N+1 → wr_en high in cycle N+1..N+2 → register file writes at edge N+2.
REQ-011 Per-channel throughput SHALL be one write per 2 cycles; with both channels saturated, the two channels SHALL alternate grants.
REQ-012 A buffer cleared by a grant SHALL NOT accept on the same edge; ready rises in the following cycle.
REQ-013 Both buffers holding the same addr SHALL be written in grant order, so the later grant's data is final.
REQ-014 pend_mask SHALL be the OR of the one-hot decodes of: a_addr buffer (if full), b_addr buffer (if full), and wr_addr (if wr_en). It SHALL be combinational from registered state only.
REQ-015 busy SHALL equal a_full OR b_full OR wr_en.
REQ-016 The block SHALL NOT produce any output X for any addr/data values, including the maximum address 2**ADDR_WIDTH-1.

Reset
REQ-017 While rst is high at a clock edge, the block SHALL:
- clear both buffers (a_ready=b_ready=1 after the edge);
- set wr_en=0, wr_addr=0, wr_data=0, drop_err=0, pend_mask=0, busy=0;
- set last_grant=B, so A wins the first tie.
REQ-018 A reset asserted mid-operation SHALL discard all buffered writes; no write issues after reset for requests accepted before it.
REQ-019 rst SHALL take priority over simultaneous valid inputs; no transfer occurs on a reset edge.

Verification
REQ-020 Single write:
- Stimulus: a_valid=1, a_addr=3, a_data=32'hDEADBEEF for one edge.
- Response: next cycle a_ready=0 and pend_mask=16'h0008; following cycle wr_en=1, wr_addr=3, wr_data=32'hDEADBEEF; then wr_en=0, busy=0.
REQ-021 Tie after reset:
- Stimulus: A (addr 1, data 1) and B (addr 2, data 2) accepted on the same edge.
- Response: wr_en cycles show addr 1 then addr 2 on consecutive grants; pend_mask=16'h0006 while both are buffered.
REQ-022 Saturation:
- Stimulus: both valids held high with incrementing data for 20 cycles.
- Response: grants strictly alternate A,B,A,B…; no request lost or duplicated (scoreboard match).
REQ-023 Protected register:
- Stimulus: b_addr=15, b_data=32'h1234 accepted.
- Response: grant cycle has wr_en=0, drop_err=1 for one cycle; wr_addr/wr_data hold their prior values.
REQ-024 Reset mid-flight:
- Stimulus: both buffers full, then rst=1 for one edge.
- Response: next cycle wr_en=0, pend_mask=0, a_ready=b_ready=1; no later write for the discarded entries.
REQ-025 Same address:
- Stimulus: A (addr 5, data 32'hA) and B (addr 5, data 32'hB) accepted together after reset.
- Response: writes issue A then B; final register 5 content is 32'hB.
